// File: rtl/rgb_pkg.sv
// Shared definitions for the RGB-to-colour-code decoder: colour codes, pixel field
// slices, default channel threshold and the exact-channel helper.
package rgb_pkg;

  localparam logic [2:0] BLACK   = 3'd0;
  localparam logic [2:0] BLUE    = 3'd1;
  localparam logic [2:0] GREEN   = 3'd2;
  localparam logic [2:0] CYAN    = 3'd3;
  localparam logic [2:0] RED     = 3'd4;
  localparam logic [2:0] MAGENTA = 3'd5;
  localparam logic [2:0] YELLOW  = 3'd6;
  localparam logic [2:0] WHITE   = 3'd7;

  localparam int R_HI = 23;
  localparam int R_LO = 16;
  localparam int G_HI = 15;
  localparam int G_LO = 8;
  localparam int B_HI = 7;
  localparam int B_LO = 0;

  localparam logic [7:0] DEF_THRESH = 8'h80;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  function automatic logic exact_chan(input logic [7:0] b);
    return (b == 8'h00) || (b == 8'hFF);
  endfunction

endpackage

// File: rtl/rgb_chan_quant.sv
// One colour channel: threshold compare to a single code bit, plus the
// "channel is exactly 0x00 or 0xFF" flag. Purely combinational.
module rgb_chan_quant
  import rgb_pkg::*;
#(
  parameter logic [7:0] THRESH = DEF_THRESH
) (
  input  logic [7:0] chan,
  output logic       bit_out,
  output logic       exact
);

  assign bit_out = (chan >= THRESH);
  assign exact   = exact_chan(chan);

endmodule

// File: rtl/rgb_to_colour.sv
// Streaming 24-bit RGB to 3-bit colour decoder with one output register; 1-cycle latency,
// full throughput, in_ready drops while a result is held against out_ready=0 or enable=0.
// Optional saturating inexact-pixel counter under RGB_INEXACT_CNT_EN.
module rgb_to_colour
  import rgb_pkg::*;
#(
  parameter logic [7:0] THRESH = DEF_THRESH
`ifdef RGB_INEXACT_CNT_EN
  ,
  parameter int         CNT_W  = 16
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [23:0] rgb_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [2:0]  colour_out,
  output logic        exact_out,
  output logic        out_valid,
  input  logic        out_ready
`ifdef RGB_INEXACT_CNT_EN
  ,
  input  logic        cnt_clr,
  output logic [CNT_W-1:0] inexact_cnt
`endif
);

  state_e     state_q, state_d;
  logic [2:0] colour_q, colour_d;
  logic       exact_q, exact_d;
  logic [2:0] hit;
  logic [2:0] chan_exact;
  logic       accept;

  rgb_chan_quant #(.THRESH(THRESH)) u_quant_r (
    .chan    (rgb_in[R_HI:R_LO]),
    .bit_out (hit[2]),
    .exact   (chan_exact[2])
  );

  rgb_chan_quant #(.THRESH(THRESH)) u_quant_g (
    .chan    (rgb_in[G_HI:G_LO]),
    .bit_out (hit[1]),
    .exact   (chan_exact[1])
  );

  rgb_chan_quant #(.THRESH(THRESH)) u_quant_b (
    .chan    (rgb_in[B_HI:B_LO]),
    .bit_out (hit[0]),
    .exact   (chan_exact[0])
  );

  assign out_valid  = (state_q == ST_FULL);
  assign in_ready   = enable && (!out_valid || out_ready);
  assign accept     = in_valid && in_ready;
  assign colour_out = colour_q;
  assign exact_out  = exact_q;

  always_comb begin
    state_d  = state_q;
    colour_d = colour_q;
    exact_d  = exact_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL:  if (!accept && out_ready) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
    // Drained results keep their code visible; only an accept overwrites it.
    if (accept) begin
      colour_d = hit;
      exact_d  = &chan_exact;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_EMPTY;
      colour_q <= 3'b000;
      exact_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      colour_q <= colour_d;
      exact_q  <= exact_d;
    end
  end

`ifdef RGB_INEXACT_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    // Clear has priority over a coincident increment.
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (accept && !(&chan_exact) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign inexact_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_rgb_to_colour.sv
// Self-checking bench for rgb_to_colour: directed scenarios plus a randomized run
// checked against a transaction-level queue model.
module tb_rgb_to_colour;
  import rgb_pkg::*;

  localparam logic [7:0] TH = 8'h80;
`ifdef RGB_INEXACT_CNT_EN
  localparam int CW = 4;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [23:0] rgb_in;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  colour_out;
  logic        exact_out;
  logic        out_valid;
  logic        out_ready;
`ifdef RGB_INEXACT_CNT_EN
  logic          cnt_clr;
  logic [CW-1:0] inexact_cnt;
  int            m_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rgb_to_colour #(
    .THRESH (TH)
`ifdef RGB_INEXACT_CNT_EN
    ,
    .CNT_W  (CW)
`endif
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .rgb_in     (rgb_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .colour_out (colour_out),
    .exact_out  (exact_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
`ifdef RGB_INEXACT_CNT_EN
    ,
    .cnt_clr    (cnt_clr),
    .inexact_cnt(inexact_cnt)
`endif
  );

  // Reference: code bit set when channel >= threshold; exact when every channel is 0 or 255.
  function automatic logic [2:0] ref_code(input logic [23:0] p);
    int r, g, b, code;
    r = int'(p[23:16]);
    g = int'(p[15:8]);
    b = int'(p[7:0]);
    code = 0;
    if (r >= int'(TH)) code += 4;
    if (g >= int'(TH)) code += 2;
    if (b >= int'(TH)) code += 1;
    return 3'(code);
  endfunction

  function automatic logic ref_exact(input logic [23:0] p);
    int ok;
    ok = 1;
    for (int k = 0; k < 3; k++) begin
      int c;
      c = int'((p >> (8 * k)) & 24'hFF);
      if (c != 0 && c != 255) ok = 0;
    end
    return logic'(ok);
  endfunction

  function automatic logic [7:0] rand_chan();
    case ($urandom_range(0, 4))
      0: return 8'h00;
      1: return 8'hFF;
      2: return TH;
      3: return TH - 8'd1;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; in_valid = 1'b1; out_ready = 1'b1; rgb_in = 24'hFFFFFF;
`ifdef RGB_INEXACT_CNT_EN
    cnt_clr = 1'b0;
`endif
    repeat (3) tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (colour_out !== 3'b000) begin errors++; $display("FAIL reset_colour got=%0d want=0", colour_out); end
    checks++; if (exact_out !== 1'b0) begin errors++; $display("FAIL reset_exact got=%b want=0", exact_out); end
`ifdef RGB_INEXACT_CNT_EN
    checks++; if (inexact_cnt !== '0) begin errors++; $display("FAIL reset_cnt got=%0d want=0", inexact_cnt); end
`endif
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_round_trip();
    logic [23:0] pix [8];
    logic [2:0]  exp_code [8];
    pix = '{24'h000000, 24'h0000FF, 24'h00FF00, 24'h00FFFF,
            24'hFF0000, 24'hFF00FF, 24'hFFFF00, 24'hFFFFFF};
    exp_code = '{BLACK, BLUE, GREEN, CYAN, RED, MAGENTA, YELLOW, WHITE};
    enable = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rgb_in = pix[i]; in_valid = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b1 || colour_out !== exp_code[i] || exact_out !== 1'b1) begin
        errors++;
        $display("FAIL round_trip[%0d] got v=%b c=%0d e=%b want v=1 c=%0d e=1",
                 i, out_valid, colour_out, exact_out, exp_code[i]);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL round_trip_drain got=%b want=0", out_valid); end
  endtask

  task automatic test_threshold();
    enable = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    rgb_in = 24'h807F80;
    tick();
    checks++;
    if (colour_out !== 3'b101 || exact_out !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL thresh_807F80 got c=%b e=%b v=%b want c=101 e=0 v=1", colour_out, exact_out, out_valid);
    end
    rgb_in = 24'h7F807F;
    tick();
    checks++;
    if (colour_out !== 3'b010 || exact_out !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL thresh_7F807F got c=%b e=%b v=%b want c=010 e=0 v=1", colour_out, exact_out, out_valid);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    enable = 1'b1; out_ready = 1'b1; in_valid = 1'b1; rgb_in = 24'hFF0000;
    tick();
    out_ready = 1'b0; rgb_in = 24'h00FF00;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got=%b want=0", i, in_ready); end
      tick();
      checks++;
      if (colour_out !== 3'd4 || out_valid !== 1'b1) begin
        errors++; $display("FAIL bp_hold[%0d] got c=%0d v=%b want c=4 v=1", i, colour_out, out_valid);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%b want=1", in_ready); end
    tick();
    checks++;
    if (colour_out !== 3'd2 || out_valid !== 1'b1) begin
      errors++; $display("FAIL bp_next got c=%0d v=%b want c=2 v=1", colour_out, out_valid);
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup got=%b want=0", out_valid); end
  endtask

  task automatic test_enable();
    enable = 1'b1; out_ready = 1'b0; in_valid = 1'b1; rgb_in = 24'h0000FF;
    tick();
    enable = 1'b0; rgb_in = 24'hFFFFFF;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL en_in_ready got=%b want=0", in_ready); end
    tick();
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL en_in_ready_drain got=%b want=0", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b0 || colour_out !== 3'd1) begin
      errors++; $display("FAIL en_drain got v=%b c=%0d want v=0 c=1", out_valid, colour_out);
    end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL en_no_accept got=%b want=0", out_valid); end
    enable = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL en_resume_ready got=%b want=1", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || colour_out !== 3'd7 || exact_out !== 1'b1) begin
      errors++; $display("FAIL en_resume got v=%b c=%0d e=%b want v=1 c=7 e=1", out_valid, colour_out, exact_out);
    end
    in_valid = 1'b0;
    tick();
  endtask

`ifdef RGB_INEXACT_CNT_EN
  task automatic test_counter();
    logic [23:0] seq [8];
    seq = '{24'h123456, 24'h000000, 24'h80FF00, 24'hFFFFFF, 24'h7F0000, 24'h00FF01, 24'hFF00FF, 24'h808080};
    enable = 1'b1; out_ready = 1'b1; in_valid = 1'b0; cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    checks++; if (inexact_cnt !== '0) begin errors++; $display("FAIL cnt_clear got=%0d want=0", inexact_cnt); end
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rgb_in = seq[i];
      tick();
    end
    in_valid = 1'b0;
    tick();
    checks++; if (inexact_cnt !== CW'(5)) begin errors++; $display("FAIL cnt_five got=%0d want=5", inexact_cnt); end
    in_valid = 1'b1; rgb_in = 24'h404040; cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0; in_valid = 1'b0;
    checks++; if (inexact_cnt !== '0) begin errors++; $display("FAIL cnt_clr_wins got=%0d want=0", inexact_cnt); end
    tick();
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rgb_in = {8'($urandom_range(1, 254)), 16'h00FF};
      tick();
    end
    in_valid = 1'b0;
    tick();
    checks++; if (inexact_cnt !== CW'(15)) begin errors++; $display("FAIL cnt_saturate got=%0d want=15", inexact_cnt); end
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
  endtask
`endif

  task automatic test_random();
    logic [23:0] q_pix [$];
    logic        exp_ready;
    logic [23:0] head;
`ifdef RGB_INEXACT_CNT_EN
    m_cnt = int'(inexact_cnt);
`endif
    for (int cyc = 0; cyc < 600; cyc++) begin
      enable    = ($urandom_range(0, 7) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      rgb_in    = {rand_chan(), rand_chan(), rand_chan()};
`ifdef RGB_INEXACT_CNT_EN
      cnt_clr   = ($urandom_range(0, 31) == 0);
`endif
      #1;
      exp_ready = enable && (q_pix.size() == 0 || out_ready);
      checks++;
      if (in_ready !== exp_ready) begin
        errors++; $display("FAIL rnd_in_ready cyc=%0d got=%b want=%b", cyc, in_ready, exp_ready);
      end
      if (q_pix.size() != 0) begin
        head = q_pix[0];
        checks++;
        if (colour_out !== ref_code(head) || exact_out !== ref_exact(head)) begin
          errors++;
          $display("FAIL rnd_data cyc=%0d pix=%06h got c=%0d e=%b want c=%0d e=%b",
                   cyc, head, colour_out, exact_out, ref_code(head), ref_exact(head));
        end
        if (out_ready) void'(q_pix.pop_front());
      end
      if (in_valid && exp_ready) q_pix.push_back(rgb_in);
`ifdef RGB_INEXACT_CNT_EN
      if (cnt_clr) m_cnt = 0;
      else if (in_valid && exp_ready && !ref_exact(rgb_in) && m_cnt < (1 << CW) - 1) m_cnt++;
`endif
      tick();
      checks++;
      if (out_valid !== (q_pix.size() != 0)) begin
        errors++; $display("FAIL rnd_out_valid cyc=%0d got=%b want=%b", cyc, out_valid, q_pix.size() != 0);
      end
`ifdef RGB_INEXACT_CNT_EN
      checks++;
      if (int'(inexact_cnt) != m_cnt) begin
        errors++; $display("FAIL rnd_cnt cyc=%0d got=%0d want=%0d", cyc, inexact_cnt, m_cnt);
      end
`endif
    end
    in_valid = 1'b0; out_ready = 1'b1; enable = 1'b1;
`ifdef RGB_INEXACT_CNT_EN
    cnt_clr = 1'b0;
`endif
    tick();
  endtask

  task automatic test_reset_midflight();
    enable = 1'b1; out_ready = 1'b0; in_valid = 1'b1; rgb_in = 24'hFFFF00;
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || colour_out !== 3'b000) begin
      errors++; $display("FAIL midreset got v=%b c=%0d want v=0 c=0", out_valid, colour_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_no_replay got=%b want=0", out_valid); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_round_trip();
    test_threshold();
    test_backpressure();
    test_enable();
`ifdef RGB_INEXACT_CNT_EN
    test_counter();
`endif
    test_random();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rgb_to_colour.md
Name: rgb_to_colour

Overview:
Streaming decoder: the inverse of the 3-bit colour to 24-bit RGB converter.
- Accepts 24-bit RGB pixels through a valid/ready handshake.
- Quantises each channel against a threshold to produce the 3-bit colour code.
- Flags whether the pixel was an exact primary colour (every channel 0x00 or 0xFF).
- Sits after a pixel source and feeds colour-indexed logic; together with the converter it closes the loop colour -> rgb -> colour.

Parameters:
THRESH, 8'h80, per-channel threshold; channel >= THRESH decodes as 1.
CNT_W, 16, width of the inexact-pixel counter (optional feature only).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous reset, active-low.
enable  input  1  when 0, no new pixels accepted; a held output still drains.
rgb_in  input  24  pixel, [23:16]=R, [15:8]=G, [7:0]=B.
in_valid  input  1  rgb_in is valid.
in_ready  output  1  block can accept a pixel this cycle.
colour_out  output  3  decoded code, [2]=R, [1]=G, [0]=B.
exact_out  output  1  1 if the source pixel had every channel exactly 0x00 or 0xFF.
out_valid  output  1  colour_out/exact_out are valid.
out_ready  input  1  downstream accepts the output.
inexact_cnt  output  CNT_W  saturating count of accepted inexact pixels (optional feature only).
cnt_clr  input  1  synchronous counter clear (optional feature only).

Behaviour:
- Reset is asynchronous on rst_n low: out_valid=0, colour_out=3'b000, exact_out=0, inexact_cnt=0. Reset mid-transfer discards the held result; nothing is replayed.
- in_ready = enable && (!out_valid || out_ready). It is combinational and never depends on in_valid.
- Accept occurs when in_valid && in_ready at a rising edge. At that edge:
  - colour_out <= {R>=THRESH, G>=THRESH, B>=THRESH}
  - exact_out <= all three channels are 0x00 or 0xFF
  - out_valid <= 1
- Latency: 1 cycle from accepting edge to out_valid. Full throughput of one pixel per cycle when out_ready=1.
- Output hold: while out_valid && !out_ready, colour_out, exact_out and out_valid stay stable and in_ready=0.
- Drain: if out_valid && out_ready and no accept occurs, out_valid <= 0. colour_out and exact_out keep their last values.
- Simultaneous drain and accept: the new result replaces the old one in the same edge and out_valid stays 1.
- enable=0: in_ready=0, but a held output still completes when out_ready=1. Re-asserting enable resumes acceptance on the same cycle.
- Pure-colour round trip: 000000->0, 0000FF->1, 00FF00->2, 00FFFF->3, FF0000->4, FF00FF->5, FFFF00->6, FFFFFF->7, each with exact_out=1.
- Boundary: a channel equal to THRESH decodes as 1; THRESH-1 decodes as 0.
- State: one output register stage, implemented as a 2-state FSM:
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on drain without accept.
  - FULL -> FULL on hold, or on drain with accept.

Optional Feature:
Macro RGB_INEXACT_CNT_EN.
- Defined: ports inexact_cnt and cnt_clr exist.
  - The counter increments on each accepted pixel whose exact bit is 0.
  - It saturates at all-ones with no wrap.
  - cnt_clr=1 clears it to 0 at the next edge. If clear and increment coincide, clear wins and the result is 0.
  - It is reset to 0 by rst_n.
- Undefined: both ports and the counter logic are absent; all other behaviour is identical.

Decomposition:
Shared package rgb_pkg holds:
- the colour code localparams (BLACK=0 ... WHITE=7)
- the RGB field slice constants (R_HI/R_LO etc.)
- the default THRESH
- a function exact_chan(byte) returning (b==8'h00 || b==8'hFF)

One natural sub-module, rgb_chan_quant: per-channel compare plus exact check, instantiated three times. Handshake and counter stay in the top module.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 -> out_valid=0, colour_out=0, inexact_cnt=0; release rst_n -> in_ready=1 with enable=1.
- Round trip: stream all 8 pure RGB values back-to-back with out_ready=1 -> colour_out 0..7 in order, one per cycle, exact_out=1, latency 1.
- Threshold boundary: rgb_in=80_7F_80 -> colour_out=3'b101, exact_out=0; rgb_in=7F_80_7F -> 3'b010, exact_out=0.
- Backpressure: accept FF0000, then out_ready=0 for 3 cycles while in_valid=1 with 00FF00 -> colour_out stays 4, in_ready=0; set out_ready=1 -> next output 2 with no loss or duplication.
- Enable gating: enable=0 with in_valid=1 -> in_ready=0, no new output; a previously held output still drains on out_ready=1.
- With RGB_INEXACT_CNT_EN: feed 5 inexact and 3 exact pixels -> inexact_cnt=5. Assert cnt_clr on the same edge as an inexact accept -> inexact_cnt=0. Preload toward saturation with CNT_W=4 and 20 inexact pixels -> inexact_cnt=15.
